// File: rtl/vga_frame_receiver_if.sv
// Video stream bundle between a sync/RGB source and the frame receiver.
// The source drives active-low hsync/vsync plus 3:3:3 colour; the receiver only listens.
interface vga_frame_receiver_if;
    logic       hsync_n;
    logic       vsync_n;
    logic [2:0] color_r;
    logic [2:0] color_g;
    logic [2:0] color_b;

    modport master (output hsync_n, vsync_n, color_r, color_g, color_b);
    modport slave  (input  hsync_n, vsync_n, color_r, color_g, color_b);
endinterface

// File: rtl/vga_frame_receiver.sv
// VGA frame receiver: recovers pixel coordinates from an hsync/vsync/RGB stream,
// measures line and frame length, declares lock after consecutive good frames
// and flags lock loss or sync timeout in a sticky error bit.
// Optional feature: define VGA_RX_CRC_EN to add a per-frame CRC-16-CCITT of the
// active pixels (frame_crc / frame_crc_vld).
module vga_frame_receiver #(
    parameter int PIX_DIV     = 2,
    parameter int H_TOTAL     = 800,
    parameter int H_BACK      = 144,
    parameter int H_ACT       = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_BACK      = 35,
    parameter int V_ACT       = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    vga_frame_receiver_if.slave   vid,
    input  logic                  err_clr,
    output logic                  pix_valid,
    output logic [9:0]            pix_x,
    output logic [9:0]            pix_y,
    output logic [8:0]            pix_rgb,
    output logic                  frame_start,
    output logic [10:0]           line_len,
    output logic [10:0]           frame_lines,
    output logic                  locked,
    output logic                  err_sticky
`ifdef VGA_RX_CRC_EN
    ,
    output logic [15:0]           frame_crc,
    output logic                  frame_crc_vld
`endif
);

    localparam logic [2:0]  DIV_LAST = 3'(PIX_DIV - 1);
    localparam logic [10:0] CNT_MAX  = 11'h7FF;
    localparam logic [10:0] H_TOT_W  = 11'(H_TOTAL);
    localparam logic [10:0] V_TOT_W  = 11'(V_TOTAL);
    localparam logic [10:0] H_LO     = 11'(H_BACK);
    localparam logic [10:0] H_HI     = 11'(H_BACK + H_ACT);
    localparam logic [10:0] V_LO     = 11'(V_BACK);
    localparam logic [10:0] V_HI     = 11'(V_BACK + V_ACT);
    localparam logic [3:0]  LOCK_N   = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state;
    logic        hs1, hs1_d, vs1, clr1;
    logic [8:0]  rgb1;
    logic [2:0]  div;
    logic [10:0] h_cnt, v_cnt;
    logic        vs_line, line_err;
    logic [3:0]  good_cnt;

    logic        hs_fall, tick, fs, timeout, line_bad, frame_bad, err_set, pix_stb;
    logic [10:0] h_inc, v_inc, h_pix, v_pix;

    // Stage-1 input registers; hs1_d keeps the previous sample for edge detect.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            hs1   <= 1'b0;
            hs1_d <= 1'b0;
            vs1   <= 1'b0;
            rgb1  <= '0;
            clr1  <= 1'b0;
        end else begin
            hs1   <= vid.hsync_n;
            hs1_d <= hs1;
            vs1   <= vid.vsync_n;
            rgb1  <= {vid.color_r, vid.color_g, vid.color_b};
            clr1  <= err_clr;
        end
    end

    // Event decode; h_pix/v_pix are the coordinates of the pixel ticked this clk.
    always_comb begin
        hs_fall   = hs1_d & ~hs1;
        tick      = hs_fall | (div == DIV_LAST);
        h_inc     = (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + 11'd1;
        v_inc     = (v_cnt == CNT_MAX) ? CNT_MAX : v_cnt + 11'd1;
        fs        = hs_fall & vs_line & ~vs1;
        h_pix     = hs_fall ? 11'd0 : h_inc;
        v_pix     = hs_fall ? (fs ? 11'd0 : v_inc) : v_cnt;
        timeout   = tick & ~hs_fall & (h_cnt == CNT_MAX - 11'd1);
        // Lines are only judged once a frame start has been seen; the line
        // in progress when SEARCH was left may be partial.
        line_bad  = (state != SEARCH) & (h_inc != H_TOT_W);
        frame_bad = line_err | line_bad | (v_inc != V_TOT_W);
        err_set   = (state == LOCKED) & (timeout | (fs & frame_bad));
        pix_stb   = tick & (state != SEARCH)
                  & (h_pix >= H_LO) & (h_pix < H_HI)
                  & (v_pix >= V_LO) & (v_pix < V_HI);
    end

    // Pixel divider, line/frame counters and line/frame length capture.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            div         <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            vs_line     <= 1'b0;
            line_err    <= 1'b0;
            line_len    <= '0;
            frame_lines <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= fs;
            if (hs_fall) begin
                div      <= '0;
                h_cnt    <= '0;
                line_len <= h_inc;
                vs_line  <= vs1;
                if (fs) begin
                    v_cnt       <= '0;
                    frame_lines <= v_inc;
                    line_err    <= 1'b0;
                end else begin
                    v_cnt <= v_inc;
                    if (line_bad)
                        line_err <= 1'b1;
                end
            end else begin
                div <= tick ? 3'd0 : div + 3'd1;
                if (tick)
                    h_cnt <= h_inc;
            end
        end
    end

    // Registered pixel strobe with active-area coordinates and colour.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_rgb   <= '0;
        end else begin
            pix_valid <= pix_stb;
            if (pix_stb) begin
                pix_x   <= 10'(h_pix - H_LO);
                pix_y   <= 10'(v_pix - V_LO);
                pix_rgb <= rgb1;
            end
        end
    end

    // Lock FSM with good-frame counter and sticky error; a new error beats err_clr.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state      <= SEARCH;
            good_cnt   <= '0;
            locked     <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            if (err_set)
                err_sticky <= 1'b1;
            else if (clr1)
                err_sticky <= 1'b0;

            if (timeout) begin
                state    <= SEARCH;
                good_cnt <= '0;
                locked   <= 1'b0;
            end else if (fs) begin
                case (state)
                    SEARCH: begin
                        state    <= TRACK;
                        good_cnt <= '0;
                    end
                    TRACK: begin
                        if (frame_bad) begin
                            good_cnt <= '0;
                        end else begin
                            good_cnt <= good_cnt + 4'd1;
                            if (good_cnt + 4'd1 == LOCK_N) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (frame_bad) begin
                            state    <= TRACK;
                            good_cnt <= '0;
                            locked   <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= SEARCH;
                        good_cnt <= '0;
                        locked   <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef VGA_RX_CRC_EN
    logic [15:0] crc_acc;

    // CRC-16-CCITT, MSB first, over one pixel zero-extended to 16 bits.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [8:0] rgb);
        logic [15:0] r;
        logic [15:0] d;
        logic        fb;
        r = c;
        d = {7'b0, rgb};
        for (int i = 15; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb)
                r = r ^ 16'h1021;
        end
        return r;
    endfunction

    // Accumulate active pixels; publish at frame start if the frame was tracked from its start.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            crc_acc       <= 16'hFFFF;
            frame_crc     <= '0;
            frame_crc_vld <= 1'b0;
        end else begin
            frame_crc_vld <= 1'b0;
            if (fs) begin
                crc_acc <= pix_stb ? crc_step(16'hFFFF, rgb1) : 16'hFFFF;
                if (state != SEARCH) begin
                    frame_crc     <= crc_acc;
                    frame_crc_vld <= 1'b1;
                end
            end else if (pix_stb) begin
                crc_acc <= crc_step(crc_acc, rgb1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_frame_receiver.sv
// Scoreboard bench for vga_frame_receiver with a shrunken video timing
// (20 px x 10 lines, 12x6 active) so many frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_frame_receiver;
    localparam int PIX_DIV     = 2;
    localparam int H_TOTAL     = 20;
    localparam int H_BACK      = 4;
    localparam int H_ACT       = 12;
    localparam int V_TOTAL     = 10;
    localparam int V_BACK      = 2;
    localparam int V_ACT       = 6;
    localparam int LOCK_FRAMES = 2;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        err_clr = 1'b0;
    logic        pix_valid, frame_start, locked, err_sticky;
    logic [9:0]  pix_x, pix_y;
    logic [8:0]  pix_rgb;
    logic [10:0] line_len, frame_lines;
`ifdef VGA_RX_CRC_EN
    logic [15:0] frame_crc;
    logic        frame_crc_vld;
    logic        crc_vld_d = 1'b0;
`endif

    vga_frame_receiver_if vid();

    vga_frame_receiver #(
        .PIX_DIV(PIX_DIV), .H_TOTAL(H_TOTAL), .H_BACK(H_BACK), .H_ACT(H_ACT),
        .V_TOTAL(V_TOTAL), .V_BACK(V_BACK), .V_ACT(V_ACT), .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .vid(vid), .err_clr(err_clr),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .frame_start(frame_start), .line_len(line_len), .frame_lines(frame_lines),
        .locked(locked), .err_sticky(err_sticky)
`ifdef VGA_RX_CRC_EN
        , .frame_crc(frame_crc), .frame_crc_vld(frame_crc_vld)
`endif
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [8:0] rgb;
    } pix_t;

    typedef struct packed {
        logic [10:0] lines;
        logic [10:0] len;
        logic        lk;
        logic        err;
        logic        crc_chk;
        logic [15:0] crc;
    } fs_t;

    pix_t        pix_q[$];
    fs_t         fs_q[$];
    pix_t        mon_pix;
    fs_t         mon_fs;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] model_crc = 16'hFFFF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] pat(input int p, input int l, input int mode, input logic [8:0] base);
        if (mode == 0)
            return base;
        return 9'((p * 7 + l * 13)) ^ base;
    endfunction

    // Reference CRC: polynomial division of the 16-bit word, one bit at a time.
    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [8:0] rgb);
        logic [15:0] r;
        logic [15:0] w;
        r = c;
        w = {7'b0, rgb};
        for (int k = 0; k < 16; k++) begin
            if ((r[15] ^ w[15 - k]) == 1'b1)
                r = (r << 1) ^ 16'h1021;
            else
                r = r << 1;
        end
        return r;
    endfunction

    // Drive one frame; push expected frame-start record and active pixels as they are issued.
    task automatic drive_frame(input bit fs_exp, input logic [10:0] exp_lines, input logic [10:0] exp_len,
                               input bit exp_lk, input bit exp_err, input bit pix_on, input int short_line,
                               input int mode, input logic [8:0] base, input bit crc_chk);
        int          len;
        logic [8:0]  c;
        fs_t         f;
        pix_t        e;
        for (int l = 0; l < V_TOTAL; l++) begin
            len = (l == short_line) ? H_TOTAL - 1 : H_TOTAL;
            for (int p = 0; p < len; p++) begin
                c = pat(p, l, mode, base);
                if (l == 0 && p == 0 && fs_exp) begin
                    f.lines   = exp_lines;
                    f.len     = exp_len;
                    f.lk      = exp_lk;
                    f.err     = exp_err;
                    f.crc_chk = crc_chk;
                    f.crc     = model_crc;
                    fs_q.push_back(f);
                    model_crc = 16'hFFFF;
                end
                if (pix_on && p >= H_BACK && p < H_BACK + H_ACT && l >= V_BACK && l < V_BACK + V_ACT) begin
                    e.x   = 10'(p - H_BACK);
                    e.y   = 10'(l - V_BACK);
                    e.rgb = c;
                    pix_q.push_back(e);
                    model_crc = crc_ref(model_crc, c);
                end
                for (int d = 0; d < PIX_DIV; d++) begin
                    @(negedge clk_clk);
                    vid.hsync_n = (p >= 2);
                    vid.vsync_n = (l >= 2);
                    {vid.color_r, vid.color_g, vid.color_b} = c;
                end
            end
        end
    endtask

    // Monitor: pop expected pixels and frame-start records whenever the DUT presents them.
    always @(negedge clk_clk) begin
        if (pix_valid) begin
            if (pix_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pix_unexpected: got x=%0d y=%0d rgb=%0h, none expected", pix_x, pix_y, pix_rgb);
            end else begin
                mon_pix = pix_q.pop_front();
                check("pix_xy_rgb", 32'({pix_x, pix_y, pix_rgb}), 32'(mon_pix));
            end
        end
        if (frame_start) begin
            if (fs_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_start_unexpected: got pulse, none expected at %0t", $time);
            end else begin
                mon_fs = fs_q.pop_front();
                check("frame_lines", 32'(frame_lines), 32'(mon_fs.lines));
                check("line_len",    32'(line_len),    32'(mon_fs.len));
                check("locked",      32'(locked),      32'(mon_fs.lk));
                check("err_sticky",  32'(err_sticky),  32'(mon_fs.err));
`ifdef VGA_RX_CRC_EN
                if (mon_fs.crc_chk) begin
                    check("frame_crc_vld", 32'(frame_crc_vld), 32'd1);
                    check("frame_crc",     32'(frame_crc),     32'(mon_fs.crc));
                end
`endif
            end
        end
`ifdef VGA_RX_CRC_EN
        if (crc_vld_d)
            check("crc_vld_pulse", 32'(frame_crc_vld), 32'd0);
        crc_vld_d = frame_crc_vld;
`endif
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_pix_valid"},   32'(pix_valid),   32'd0);
        check({tag, "_pix_x"},       32'(pix_x),       32'd0);
        check({tag, "_pix_y"},       32'(pix_y),       32'd0);
        check({tag, "_pix_rgb"},     32'(pix_rgb),     32'd0);
        check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        check({tag, "_line_len"},    32'(line_len),    32'd0);
        check({tag, "_frame_lines"}, 32'(frame_lines), 32'd0);
        check({tag, "_locked"},      32'(locked),      32'd0);
        check({tag, "_err_sticky"},  32'(err_sticky),  32'd0);
    endtask

    initial begin
        vid.hsync_n = 1'b1;
        vid.vsync_n = 1'b1;
        vid.color_r = 3'd0;
        vid.color_g = 3'd0;
        vid.color_b = 3'd0;
        repeat (3) @(negedge clk_clk);
        check_all_zero("reset");
        reset_reset_n = 1'b1;
        repeat (6) @(negedge clk_clk);

        // F1 in SEARCH (vs_line starts low, so no frame start yet); F2..F4 lock up.
        drive_frame(0, 11'd0,  11'd0,  0, 0, 0, -1, 0, 9'h000, 0);
        drive_frame(1, 11'd11, 11'd20, 0, 0, 1, -1, 0, 9'h157, 0);
        drive_frame(1, 11'd10, 11'd20, 0, 0, 1, -1, 1, 9'h000, 0);
        drive_frame(1, 11'd10, 11'd20, 1, 0, 1,  5, 1, 9'h0A5, 0);

        // F5 starts with lock lost (short line in F4); clear the error mid-frame.
        fork
            drive_frame(1, 11'd10, 11'd20, 0, 1, 1, -1, 1, 9'h1C3, 0);
            begin
                repeat (120) @(negedge clk_clk);
                err_clr = 1'b1;
                @(negedge clk_clk);
                err_clr = 1'b0;
                repeat (4) @(negedge clk_clk);
                check("err_clr", 32'(err_sticky), 32'd0);
            end
        join
        drive_frame(1, 11'd10, 11'd20, 0, 0, 1, -1, 1, 9'h055, 0);
        drive_frame(1, 11'd10, 11'd20, 1, 0, 1, -1, 0, 9'h1FF, 0);

        // hsync stuck high while locked -> timeout
        vid.hsync_n = 1'b1;
        repeat (4200) @(negedge clk_clk);
        check("timeout_locked",    32'(locked),     32'd0);
        check("timeout_err",       32'(err_sticky), 32'd1);
        check("timeout_pix_valid", 32'(pix_valid),  32'd0);

        // F8: frame start after timeout, then reset mid-line during vertical blanking
        fork
            drive_frame(1, 11'd10, 11'd2047, 0, 1, 0, -1, 0, 9'h000, 0);
            begin
                repeat (60) @(negedge clk_clk);
                reset_reset_n = 1'b0;
                #1;
                check_all_zero("midreset");
                repeat (3) @(negedge clk_clk);
                reset_reset_n = 1'b1;
            end
        join

        // relock takes LOCK_FRAMES+1 frame starts; F10 is all-zero colour
        drive_frame(1, 11'd9,  11'd20, 0, 0, 1, -1, 1, 9'h111, 0);
        drive_frame(1, 11'd10, 11'd20, 0, 0, 1, -1, 0, 9'h000, 0);
        drive_frame(1, 11'd10, 11'd20, 1, 0, 1, -1, 1, 9'h0F0, 1);

        repeat (10) @(negedge clk_clk);
        check("pix_queue_drained", 32'(pix_q.size()), 32'd0);
        check("fs_queue_drained",  32'(fs_q.size()),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
